am_similarity_engine: RTL and testbench
=======================================

# am_similarity_engine

Parametrised associative-memory search engine for the sparse HDC classifier. It streams a query hypervector in `SEQ_CYCLE_COUNT` segments of `DIMS_PER_CC` bits, ANDs each segment with the matching segment of every class hypervector, and accumulates per-class popcounts. It then scans the accumulated scores and returns the best-matching class over a valid/ready handshake. It sits between the query encoder and the classification output, and supersedes the purely combinational AND stage.

## Interface
- `NUM_CLASSES`, default 26: number of class hypervectors.
- `DIMS_PER_CC`, default 1024: bits per segment.
- `SEQ_CYCLE_COUNT`, default 4: segments per hypervector.
- `clk`, input, 1: single clock.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begin a new query; honoured only in IDLE.
- `in_valid`, input, 1: `query_hv_segment` is valid.
- `in_ready`, output, 1: segment accepted on `in_valid & in_ready`.
- `query_hv_segment`, input, `DIMS_PER_CC`: current query segment.
- `seg_idx`, output, `SEG_W = $clog2(SEQ_CYCLE_COUNT)`: index of the segment expected next.
- `binary_class_hvs`, input, `[SEQ_CYCLE_COUNT-1:0][DIMS_PER_CC-1:0]` × `NUM_CLASSES`: class hypervectors, held stable for the whole query.
- `enable_mask`, input, `DIMS_PER_CC`: per-dimension enable for the current segment. Present only with `AM_PRUNE_EN`.
- `out_valid`, output, 1: result is valid.
- `out_ready`, input, 1: downstream accepts the result.
- `result_class`, output, `$clog2(NUM_CLASSES)`: winning class index.
- `result_score`, output, `SCORE_W = $clog2(DIMS_PER_CC*SEQ_CYCLE_COUNT+1)`: winning score.

## Operation
- FSM states: IDLE, ACCUM, SCAN, DONE.
- **IDLE**
  - `start` clears all accumulators and `seg_idx`, then goes to ACCUM.
  - `in_ready` is 0.
- **ACCUM**
  - `in_ready` is 1.
  - On each handshake, for every class c: `acc[c] += popcount(binary_class_hvs[c][seg_idx] & query_hv_segment)`, then `seg_idx++`.
  - The handshake on segment `SEQ_CYCLE_COUNT-1` goes to SCAN with `scan_idx = 0`, and `seg_idx` wraps to 0.
  - Idle cycles with `in_valid = 0` change nothing.
- **SCAN**
  - Visits one class per cycle, `scan_idx` from 0 to `NUM_CLASSES-1`.
  - `scan_idx = 0` unconditionally loads the best index/score.
  - Each later index replaces the best only if strictly greater, so ties go to the lowest index.
  - Goes to DONE after visiting `NUM_CLASSES-1`.
- **DONE**
  - `out_valid` is 1; `result_class` and `result_score` are held.
  - Goes to IDLE on `out_ready`.
- `start` outside IDLE is ignored and has no queueing effect.
- Arithmetic
  - Per-segment popcount width is `$clog2(DIMS_PER_CC+1)`.
  - Accumulators are `SCORE_W` bits, zero-extended adds, and cannot overflow.
  - Maximum score is `DIMS_PER_CC*SEQ_CYCLE_COUNT`.
- Reset, including mid-query
  - State returns to IDLE; accumulators, `seg_idx` and `scan_idx` clear to 0.
  - Reset values: `in_ready = 0`, `seg_idx = 0`, `out_valid = 0`, `result_class = 0`, `result_score = 0`.
  - Partial accumulation is discarded.
- `rst` has priority over every other input in the same cycle.

## Timing
- Accumulation: one segment per cycle; accumulators update on the handshake edge with no extra pipeline stage.
- Result latency: `out_valid` rises exactly `NUM_CLASSES` cycles after the edge accepting the final segment (26 at default).
- Minimum query time: 1 (start) + `SEQ_CYCLE_COUNT` + `NUM_CLASSES` + 1 (`out_ready`) cycles.
- `out_valid` deasserts on the edge where `out_valid & out_ready`.
- `start` may be accepted in the cycle after that edge.
- Outputs are registered; no combinational path from inputs to `out_valid`, `result_*` or `in_ready`.

## Configuration
- `AM_PRUNE_EN` defined
  - `enable_mask` port exists.
  - AND term becomes `binary_class_hvs[c][seg_idx] & query_hv_segment & enable_mask`, so pruned dimensions contribute 0 to every class.
  - `enable_mask` is sampled with the segment on the handshake.
- `AM_PRUNE_EN` undefined
  - No `enable_mask` port; all dimensions are enabled.
  - Behaviour is otherwise identical.

## Structure
- Package `am_pkg` holds:
  - FSM state enum `am_state_t` (IDLE, ACCUM, SCAN, DONE).
  - Default constants `NUM_CLASSES`, `DIMS_PER_CC`, `SEQ_CYCLE_COUNT`.
  - Width helper functions for `SEG_W`, `SCORE_W` and popcount width.
- Sub-module `am_popcount`
  - Parametrised on width; combinational adder-tree popcount.
  - Instanced once per class via `generate`.
- Top level contains the AND array, accumulators, FSM and argmax scan.

## Test plan
- **Reset:** hold `rst` 3 cycles mid-ACCUM -> all outputs 0, `in_ready = 0`, `seg_idx = 0`.
- **Single match:** class 5 all-ones, others all-zero, query all-ones over 4 segments -> `result_class = 5`, `result_score = 4096`, `out_valid` exactly 26 cycles after the last handshake.
- **Tie:** classes 3 and 7 each score 100, others lower -> `result_class = 3`, `result_score = 100`.
- **Backpressure:** `in_valid` gapped (1, 0, 0, 1, ...) and `out_ready` low for 10 cycles; `start` pulsed in DONE -> scores unchanged by the gaps, result held stable, `start` ignored, IDLE only after `out_ready`.
- **Pruning (`AM_PRUNE_EN`):** `enable_mask = 0x...FFFF` low 512 bits set, class 0 and query all-ones -> `result_score = 2048`.
- **Reset recovery:** reset after 2 segments, then a full query where class 1 matches 10 bits per segment -> `result_score = 40` with no stale contribution.

Source files
------------

// File: rtl/am_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | am_pkg : shared types, default sizes and width helpers for am_* modules. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package am_pkg;

  localparam int NUM_CLASSES     = 26;
  localparam int DIMS_PER_CC     = 1024;
  localparam int SEQ_CYCLE_COUNT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } am_state_t;

  // Index widths never collapse to zero so single-entry configs still elaborate.
  function automatic int idx_w_f(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int seg_w_f(input int seq_cycles);
    return idx_w_f(seq_cycles);
  endfunction

  function automatic int score_w_f(input int dims, input int seq_cycles);
    return $clog2(dims * seq_cycles + 1);
  endfunction

  function automatic int pc_w_f(input int dims);
    return $clog2(dims + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/am_popcount.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | am_popcount : combinational balanced adder-tree population count.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module am_popcount #(
  parameter int WIDTH = 1024,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] count_o
);

  localparam int LEVELS = (WIDTH <= 1) ? 0 : $clog2(WIDTH);
  localparam int LEAVES = 1 << LEVELS;

  // Each level halves the node count; partial sums never exceed WIDTH, so CNT_W suffices.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    logic [CNT_W-1:0] node [LEAVES >> l];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < LEAVES; i++) begin : g_bit
        if (i < WIDTH) begin : g_used
          assign node[i] = CNT_W'(data_i[i]);
        end else begin : g_pad
          assign node[i] = '0;
        end
      end
    end else begin : g_node
      for (genvar i = 0; i < (LEAVES >> l); i++) begin : g_add
        assign node[i] = g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
      end
    end
  end

  assign count_o = g_lvl[LEVELS].node[0];

endmodule
`default_nettype wire

// File: rtl/am_similarity_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | am_similarity_engine : segment-streamed AND/popcount associative search  |
// | with argmax scan. Optional macro AM_PRUNE_EN adds the enable_mask port.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module am_similarity_engine
  import am_pkg::*;
#(
  parameter int NUM_CLASSES     = am_pkg::NUM_CLASSES,
  parameter int DIMS_PER_CC     = am_pkg::DIMS_PER_CC,
  parameter int SEQ_CYCLE_COUNT = am_pkg::SEQ_CYCLE_COUNT,
  localparam int SEG_W   = seg_w_f(SEQ_CYCLE_COUNT),
  localparam int CLS_W   = idx_w_f(NUM_CLASSES),
  localparam int SCORE_W = score_w_f(DIMS_PER_CC, SEQ_CYCLE_COUNT)
) (
  input  logic                                                     clk,
  input  logic                                                     rst,
  input  logic                                                     start,
  input  logic                                                     in_valid,
  output logic                                                     in_ready,
  input  logic [DIMS_PER_CC-1:0]                                   query_hv_segment,
  output logic [SEG_W-1:0]                                         seg_idx,
  input  logic [NUM_CLASSES-1:0][SEQ_CYCLE_COUNT-1:0][DIMS_PER_CC-1:0] binary_class_hvs,
`ifdef AM_PRUNE_EN
  input  logic [DIMS_PER_CC-1:0]                                   enable_mask,
`endif
  output logic                                                     out_valid,
  input  logic                                                     out_ready,
  output logic [CLS_W-1:0]                                         result_class,
  output logic [SCORE_W-1:0]                                       result_score
);

  localparam int                PC_W     = pc_w_f(DIMS_PER_CC);
  localparam logic [SEG_W-1:0]  LAST_SEG = SEG_W'(SEQ_CYCLE_COUNT - 1);
  localparam logic [CLS_W-1:0]  LAST_CLS = CLS_W'(NUM_CLASSES - 1);

  am_state_t          state_q, state_d;
  logic [SEG_W-1:0]   seg_idx_q, seg_idx_d;
  logic [CLS_W-1:0]   scan_idx_q, scan_idx_d;
  logic [CLS_W-1:0]   best_idx_q, best_idx_d;
  logic [SCORE_W-1:0] best_score_q, best_score_d;
  logic [SCORE_W-1:0] acc_q [NUM_CLASSES];
  logic [SCORE_W-1:0] acc_d [NUM_CLASSES];
  logic [PC_W-1:0]    seg_pc [NUM_CLASSES];
  logic [DIMS_PER_CC-1:0] seg_mask;

`ifdef AM_PRUNE_EN
  assign seg_mask = enable_mask;
`else
  assign seg_mask = '1;
`endif

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_class
    am_popcount #(
      .WIDTH (DIMS_PER_CC),
      .CNT_W (PC_W)
    ) u_popcount (
      .data_i  (binary_class_hvs[c][seg_idx_q] & query_hv_segment & seg_mask),
      .count_o (seg_pc[c])
    );
  end

  always_comb begin
    state_d      = state_q;
    seg_idx_d    = seg_idx_q;
    scan_idx_d   = scan_idx_q;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      acc_d[c] = acc_q[c];
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ACCUM;
          seg_idx_d = '0;
          for (int c = 0; c < NUM_CLASSES; c++) begin
            acc_d[c] = '0;
          end
        end
      end
      ACCUM: begin
        if (in_valid) begin
          for (int c = 0; c < NUM_CLASSES; c++) begin
            acc_d[c] = acc_q[c] + SCORE_W'(seg_pc[c]);
          end
          if (seg_idx_q == LAST_SEG) begin
            seg_idx_d  = '0;
            scan_idx_d = '0;
            state_d    = SCAN;
          end else begin
            seg_idx_d = seg_idx_q + 1'b1;
          end
        end
      end
      SCAN: begin
        // Strict greater-than keeps the lowest index on ties.
        if ((scan_idx_q == '0) || (acc_q[scan_idx_q] > best_score_q)) begin
          best_idx_d   = scan_idx_q;
          best_score_d = acc_q[scan_idx_q];
        end
        if (scan_idx_q == LAST_CLS) begin
          state_d = DONE;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      seg_idx_q    <= '0;
      scan_idx_q   <= '0;
      best_idx_q   <= '0;
      best_score_q <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      state_q      <= state_d;
      seg_idx_q    <= seg_idx_d;
      scan_idx_q   <= scan_idx_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        acc_q[c] <= acc_d[c];
      end
    end
  end

  assign in_ready     = (state_q == ACCUM);
  assign out_valid    = (state_q == DONE);
  assign seg_idx      = seg_idx_q;
  assign result_class = best_idx_q;
  assign result_score = best_score_q;

endmodule
`default_nettype wire

// File: tb/tb_am_similarity_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_am_similarity_engine : self-checking bench for am_similarity_engine.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_am_similarity_engine;

  localparam int NC      = 26;
  localparam int D       = 1024;
  localparam int S       = 4;
  localparam int SEG_W   = 2;
  localparam int CLS_W   = 5;
  localparam int SCORE_W = 13;

  logic clk = 1'b0;
  logic rst, start, in_valid, in_ready, out_valid, out_ready;
  logic [D-1:0]               query_hv_segment;
  logic [D-1:0]               enable_mask;
  logic [SEG_W-1:0]           seg_idx;
  logic [NC-1:0][S-1:0][D-1:0] class_hvs;
  logic [S-1:0][D-1:0]        q_segs;
  logic [CLS_W-1:0]           result_class;
  logic [SCORE_W-1:0]         result_score;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  am_similarity_engine dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .query_hv_segment (query_hv_segment),
    .seg_idx          (seg_idx),
    .binary_class_hvs (class_hvs),
`ifdef AM_PRUNE_EN
    .enable_mask      (enable_mask),
`endif
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .result_class     (result_class),
    .result_score     (result_score)
  );

  typedef struct {
    int hot;
    int hot_bits;
    int tie;
    int bg;
    int exp_cls;
    int exp_score;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Whole-hypervector reference: score = popcount over all S*D dims, lowest index wins ties.
  task automatic model(output int cls, output int score);
    logic [S*D-1:0] qf, mf, hf;
    int best, sc;
    best = -1;
    cls  = 0;
    qf = q_segs;
    mf = {S{enable_mask}};
    for (int c = 0; c < NC; c++) begin
      hf = class_hvs[c];
      sc = $countones(hf & qf & mf);
      if (sc > best) begin
        best = sc;
        cls  = c;
      end
    end
    score = best;
  endtask

  task automatic build(input int hot, input int hot_bits, input int tie, input int bg);
    logic [D-1:0] ones;
    int n;
    ones = '1;
    for (int c = 0; c < NC; c++) begin
      n = (c == hot || c == tie) ? hot_bits : bg;
      for (int s = 0; s < S; s++) begin
        class_hvs[c][s] = (n == 0) ? '0 : (ones >> (D - n));
      end
    end
    q_segs = '1;
  endtask

  // gap_mode: 0 back-to-back, 1 two idle cycles between segments, 2 random gaps.
  task automatic run_query(input string tag, input int gap_mode, input int hold,
                           input int exp_cls, input int exp_score);
    int g, cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int s = 0; s < S; s++) begin
      g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? ((s == 0) ? 0 : 2) : $urandom_range(0, 3);
      in_valid = 1'b0;
      query_hv_segment = '1;
      repeat (g) begin @(posedge clk); #1; end
      query_hv_segment = q_segs[s];
      in_valid = 1'b1;
      check({tag, " seg_idx"}, seg_idx, s);
      @(posedge clk); #1;
      in_valid = 1'b0;
      query_hv_segment = '1;
    end
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, cyc, NC);
    check({tag, " class"}, result_class, exp_cls);
    check({tag, " score"}, result_score, exp_score);
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        start = (h == 3);
        @(posedge clk); #1;
      end
      start = 1'b0;
      check({tag, " held valid"}, out_valid, 1);
      check({tag, " held class"}, result_class, exp_cls);
      check({tag, " held score"}, result_score, exp_score);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " valid drop"}, out_valid, 0);
    check({tag, " idle in_ready"}, in_ready, 0);
    if (hold > 0) begin
      repeat (2) begin @(posedge clk); #1; end
      check({tag, " start not queued"}, in_ready, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int mc, ms;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    query_hv_segment = '0; enable_mask = '1; class_hvs = '0; q_segs = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset in_ready", in_ready, 0);
    check("reset seg_idx", seg_idx, 0);
    check("reset out_valid", out_valid, 0);
    check("reset class", result_class, 0);
    check("reset score", result_score, 0);

    tbl[0] = '{5,  1024, -1, 0,   5,  4096};
    tbl[1] = '{3,  25,   7,  10,  3,  100};
    tbl[2] = '{0,  0,    -1, 0,   0,  0};
    tbl[3] = '{25, 1,    -1, 0,   25, 4};
    tbl[4] = '{12, 500,  20, 3,   12, 2000};
    tbl[5] = '{25, 1000, -1, 999, 25, 4000};
    for (int i = 0; i < 6; i++) begin
      build(tbl[i].hot, tbl[i].hot_bits, tbl[i].tie, tbl[i].bg);
      run_query($sformatf("tbl%0d", i), 0, 0, tbl[i].exp_cls, tbl[i].exp_score);
    end

    // Reset in the middle of accumulation, with a large partial score pending.
    build(1, 1024, -1, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    query_hv_segment = '1;
    in_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    check("pre-reset seg_idx", seg_idx, 2);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("midreset in_ready", in_ready, 0);
    check("midreset seg_idx", seg_idx, 0);
    check("midreset out_valid", out_valid, 0);
    check("midreset class", result_class, 0);
    check("midreset score", result_score, 0);
    build(1, 10, -1, 0);
    run_query("recovery", 0, 0, 1, 40);

    build(9, 77, -1, 5);
    run_query("backpressure", 1, 10, 9, 308);

`ifdef AM_PRUNE_EN
    build(0, 1024, -1, 0);
    enable_mask = '0;
    enable_mask[511:0] = '1;
    run_query("prune", 0, 0, 0, 2048);
    enable_mask = '1;
`endif

    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < NC; c++)
        for (int s = 0; s < S; s++)
          for (int w = 0; w < D / 32; w++)
            class_hvs[c][s][w*32 +: 32] = $urandom();
      for (int s = 0; s < S; s++)
        for (int w = 0; w < D / 32; w++)
          q_segs[s][w*32 +: 32] = $urandom();
      model(mc, ms);
      run_query($sformatf("rand%0d", r), 2, 0, mc, ms);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
